// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   ADDR_WIDTH / DATA_WIDTH / BE_WIDTH : macro geometry (8192 x 32, 4 byte lanes)
//   arb_state_t                        : sequencer state (INIT zero-fill, RUN)
//   SRAM_IDLE                          : macro control pins for a no-access cycle
package sram_arb_pkg;

  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                cen;
    logic                gwen;
    logic [BE_WIDTH-1:0] ben;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_IDLE = '{cen: 1'b1, gwen: 1'b1, ben: {BE_WIDTH{1'b1}}};

endpackage

// File: rtl/sram_arbiter_2p_rr_arb_2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : arbitration enable; no grant while low
//   req[1:0]   : requests (bit 0 = m0, bit 1 = m1)
//   gnt[1:0]   : one-hot grant, combinational from req
// `last` holds the most recently granted port; on a conflict the other port
// wins. It resets to 1 so m0 takes the first conflict.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b01)      gnt = 2'b01;
      else if (req == 2'b10) gnt = 2'b10;
      else if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter and zero-fill sequencer for the 8192x32
// single-port byte-enable SRAM macro.
//   clk, rst_n            : clock, synchronous active-low reset
//   mX_req/gnt            : request / same-cycle grant per port
//   mX_we/be/addr/wdata   : access attributes of the requesting port
//   mX_rvalid/rdata       : response, one cycle after the grant
//   init_done_o           : high once the array is cleared (or clearing skipped)
//   sram_*                : active-low macro pins; sram_q_i is read data
//
// state | meaning
// INIT  | writing zero to every word, clr_cnt walks 0..depth-1, no grants
// RUN   | normal arbitration between m0 and m1
module sram_arbiter_2p
  import sram_arb_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_WIDTH     = sram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = sram_arb_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    init_done_o,
  output logic                    sram_cen_o,
  output logic                    sram_gwen_o,
  output logic [DATA_WIDTH/8-1:0] sram_ben_o,
  output logic [ADDR_WIDTH-1:0]   sram_a_o,
  output logic [DATA_WIDTH-1:0]   sram_d_o,
  input  logic [DATA_WIDTH-1:0]   sram_q_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [1:0]            gnt;
  logic                  arb_en;
  logic                  gsel;
  logic                  gwe;
  logic                  rv_q, rsel_q, rwe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt_q <= '0;
      rv_q      <= 1'b0;
      rsel_q    <= 1'b0;
      rwe_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
      rv_q   <= |gnt;
      rsel_q <= gsel;
      rwe_q  <= gwe;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && (&clr_cnt_q)) state_d = RUN;
  end

  // rst_n gates the enable so grants drop combinationally while reset is held.
  assign arb_en = rst_n & (state_q == RUN);

  rr_arb_2 u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({m1_req_i, m0_req_i}),
    .gnt   (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign gsel     = gnt[1];
  assign gwe      = gsel ? m1_we_i : m0_we_i;

  always_comb begin
    sram_cen_o  = SRAM_IDLE.cen;
    sram_gwen_o = SRAM_IDLE.gwen;
    sram_ben_o  = {BE_W{SRAM_IDLE.ben[0]}};
    sram_a_o    = '0;
    sram_d_o    = '0;
    if (rst_n && state_q == INIT) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = 1'b0;
      sram_ben_o  = '0;
      sram_a_o    = clr_cnt_q;
    end else if (|gnt) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = ~gwe;
      // Reads keep all lanes disabled so the macro never sees a partial write.
      sram_ben_o  = gwe ? ~(gsel ? m1_be_i : m0_be_i) : '1;
      sram_a_o    = gsel ? m1_addr_i : m0_addr_i;
      sram_d_o    = gsel ? m1_wdata_i : m0_wdata_i;
    end
  end

  // A response pending when reset arrives is suppressed immediately.
  assign m0_rvalid_o = rst_n & rv_q & ~rsel_q;
  assign m1_rvalid_o = rst_n & rv_q & rsel_q;
  assign m0_rdata_o  = (m0_rvalid_o & ~rwe_q) ? sram_q_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o & ~rwe_q) ? sram_q_i : '0;

  assign init_done_o = (state_q == RUN);

endmodule

// File: tb/tb_sram_arbiter_2p.sv
module tb_sram_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [3:0]  m0_be_i;
  logic [12:0] m0_addr_i;
  logic [31:0] m0_wdata_i, m0_rdata_o;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [3:0]  m1_be_i;
  logic [12:0] m1_addr_i;
  logic [31:0] m1_wdata_i, m1_rdata_o;
  logic        init_done_o;
  logic        sram_cen_o, sram_gwen_o;
  logic [3:0]  sram_ben_o;
  logic [12:0] sram_a_o;
  logic [31:0] sram_d_o, sram_q_i;

  always #5 clk = ~clk;

  sram_arbiter_2p dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .init_done_o(init_done_o),
    .sram_cen_o(sram_cen_o), .sram_gwen_o(sram_gwen_o), .sram_ben_o(sram_ben_o),
    .sram_a_o(sram_a_o), .sram_d_o(sram_d_o), .sram_q_i(sram_q_i)
  );

  // Behavioural SRAM macro, preloaded with junk so the zero-fill is visible.
  logic [31:0] mem [0:8191];
  logic        fill_junk;
  always @(posedge clk) begin
    if (fill_junk) begin
      for (int i = 0; i < 8192; i++) mem[i] <= $urandom | 32'h1;
    end else if (!sram_cen_o) begin
      if (!sram_gwen_o) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben_o[b]) mem[sram_a_o][8*b +: 8] <= sram_d_o[8*b +: 8];
      end else begin
        sram_q_i <= mem[sram_a_o];
      end
    end
  end

  // Reference model state
  int          total, bad;
  int          m_last;
  logic        pend_v;
  int          pend_p;
  logic [31:0] pend_d;
  logic [31:0] exp_mem [0:8191];

  localparam logic [50:0] PINS_IDLE = {1'b1, 1'b1, 4'hF, 13'h0, 32'h0};

  function automatic logic [50:0] pins();
    return {sram_cen_o, sram_gwen_o, sram_ben_o, sram_a_o, sram_d_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    m_last = 1;
    pend_v = 1'b0;
    for (int k = 0; k < n; k++) begin
      #4;
      chk("rst_gnt", 64'({m1_gnt_o, m0_gnt_o}), 64'(0));
      chk("rst_pins", 64'(pins()), 64'(PINS_IDLE));
      chk("rst_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'(0));
      chk("rst_rdata", {m1_rdata_o, m0_rdata_o}, 64'(0));
      chk("rst_init_done", 64'(init_done_o), 64'(0));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic init_pass(input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      chk("init_pins", 64'(pins()), 64'({2'b00, 4'h0, 13'(i), 32'h0}));
      chk("init_gnt", 64'({m1_gnt_o, m0_gnt_o}), 64'(0));
      chk("init_done_low", 64'(init_done_o), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_cycle(input logic r0, input logic w0, input logic [3:0] b0,
                           input logic [12:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [3:0] b1,
                           input logic [12:0] a1, input logic [31:0] d1,
                           output logic [1:0] gobs);
    int          eg;
    logic        we;
    logic [3:0]  be;
    logic [12:0] a;
    logic [31:0] d;
    logic [50:0] ep;
    m0_req_i = r0; m0_we_i = w0; m0_be_i = b0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_be_i = b1; m1_addr_i = a1; m1_wdata_i = d1;
    if (r0 && r1)  eg = (m_last == 1) ? 0 : 1;
    else if (r0)   eg = 0;
    else if (r1)   eg = 1;
    else           eg = -1;
    we = (eg == 1) ? w1 : w0;
    be = (eg == 1) ? b1 : b0;
    a  = (eg == 1) ? a1 : a0;
    d  = (eg == 1) ? d1 : d0;
    if (eg < 0) ep = PINS_IDLE;
    else        ep = {1'b0, ~we, (we ? ~be : 4'hF), a, d};
    #4;
    gobs = {m1_gnt_o, m0_gnt_o};
    chk("gnt", 64'(gobs), 64'((eg == 0) ? 2'b01 : (eg == 1) ? 2'b10 : 2'b00));
    chk("pins", 64'(pins()), 64'(ep));
    chk("rvalid0", 64'(m0_rvalid_o), 64'(pend_v && pend_p == 0));
    chk("rvalid1", 64'(m1_rvalid_o), 64'(pend_v && pend_p == 1));
    chk("rdata0", 64'(m0_rdata_o), 64'((pend_v && pend_p == 0) ? pend_d : 32'h0));
    chk("rdata1", 64'(m1_rdata_o), 64'((pend_v && pend_p == 1) ? pend_d : 32'h0));
    chk("init_done", 64'(init_done_o), 64'(1));
    @(posedge clk);
    pend_v = (eg >= 0);
    pend_p = eg;
    pend_d = we ? 32'h0 : exp_mem[a];
    if (eg >= 0) begin
      m_last = eg;
      if (we)
        for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    #1;
  endtask

  logic [1:0]  g;
  logic [12:0] ra0, ra1;

  initial begin
    total = 0; bad = 0; m_last = 1; pend_v = 1'b0; pend_p = 0; pend_d = '0;
    rst_n = 1'b0; fill_junk = 1'b1; sram_q_i = '0;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_be_i = 4'h0; m0_addr_i = 13'h0AAA; m0_wdata_i = '0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'h0; m1_addr_i = '0; m1_wdata_i = '0;
    @(posedge clk); #1;
    fill_junk = 1'b0;
    do_reset(3);

    // Partial fill interrupted at clr_cnt = 100
    init_pass(100);
    #4;
    chk("init_pins_100", 64'(pins()), 64'({2'b00, 4'h0, 13'd100, 32'h0}));
    rst_n = 1'b0;
    #1;
    chk("midinit_pins_idle", 64'(pins()), 64'(PINS_IDLE));
    chk("midinit_done", 64'(init_done_o), 64'(0));
    @(posedge clk); #1;
    do_reset(2);

    // Full fill with m0 requesting throughout
    m1_req_i = 1'b0;
    init_pass(8192);
    for (int i = 0; i < 8192; i++) exp_mem[i] = 32'h0;
    run_cycle(1, 0, 4'h0, 13'h0AAA, 32'h0, 0, 0, 4'h0, 13'h0, 32'h0, g);
    chk("first_run_gnt", 64'(g), 64'(2'b01));

    // Directed write then read on m1
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 1, 1, 4'b0101, 13'h0123, 32'hDEADBEEF, g);
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 1, 0, 4'h0, 13'h0123, 32'h0, g);
    #1;
    chk("rd_0123_valid", 64'(m1_rvalid_o), 64'(1));
    chk("rd_0123_data", 64'(m1_rdata_o), 64'(32'h00AD00EF));
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 1, 0, 4'h0, 13'h1FFF, 32'h0, g);
    #1;
    chk("rd_1fff_valid", 64'(m1_rvalid_o), 64'(1));
    chk("rd_1fff_data", 64'(m1_rdata_o), 64'(0));

    // Continuous contention
    for (int k = 0; k < 6; k++) begin
      run_cycle(1, 0, 4'h0, 13'(k), 32'h0, 1, 0, 4'h0, 13'(k + 8), 32'h0, g);
      chk("contention_order", 64'(g), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
    end
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 0, 0, 4'h0, 13'h0, 32'h0, g);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      ra0 = ($urandom % 4 == 0) ? 13'($urandom) : 13'($urandom % 16);
      ra1 = ($urandom % 4 == 0) ? 13'($urandom) : 13'($urandom % 16);
      run_cycle(1'($urandom), 1'($urandom), 4'($urandom), ra0, $urandom,
                1'($urandom), 1'($urandom), 4'($urandom), ra1, $urandom, g);
    end
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 0, 0, 4'h0, 13'h0, 32'h0, g);

    // Reset one cycle after a read grant to m0 (leaves last = 0 before reset)
    run_cycle(1, 0, 4'h0, 13'h0123, 32'h0, 0, 0, 4'h0, 13'h0, 32'h0, g);
    rst_n = 1'b0; m0_req_i = 1'b1; m1_req_i = 1'b1;
    #4;
    chk("midrun_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'(0));
    chk("midrun_gnt", 64'({m1_gnt_o, m0_gnt_o}), 64'(0));
    chk("midrun_pins", 64'(pins()), 64'(PINS_IDLE));
    @(posedge clk); #1;
    do_reset(2);
    init_pass(8192);
    for (int i = 0; i < 8192; i++) exp_mem[i] = 32'h0;
    run_cycle(1, 0, 4'h0, 13'h0005, 32'h0, 1, 0, 4'h0, 13'h0006, 32'h0, g);
    chk("post_reset_conflict", 64'(g), 64'(2'b01));
    run_cycle(0, 0, 4'h0, 13'h0, 32'h0, 0, 0, 4'h0, 13'h0, 32'h0, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_2p.md
# sram_arbiter_2p

Two-port round-robin arbiter and init sequencer in front of the 8192x32 single-port byte-enable SRAM macro. It shares the macro between two requesters, e.g. instruction fetch on m0 and data load/store on m1, using a req/gnt/rvalid protocol. It converts the winning request into the macro's active-low CEN/GWEN/BEN pins. After reset it can optionally zero-fill the whole array before granting any request.

## Interface
- CLEAR_ON_RESET, default 1: 1 = zero-fill all 8192 words after reset; 0 = skip init.
- ADDR_WIDTH, default 13: word address width; array depth is 2**ADDR_WIDTH.
- DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- m0_req_i / m1_req_i  in  1  access request, held until granted.
- m0_gnt_o / m1_gnt_o  out  1  grant, combinational, same cycle as the request.
- mX_we_i  in  1  1 = write, 0 = read.
- mX_be_i  in  4  byte enables, active-high.
- mX_addr_i  in  13  word address.
- mX_wdata_i  in  32  write data.
- mX_rvalid_o  out  1  response valid, exactly one cycle after the grant.
- mX_rdata_o  out  32  read data, valid when mX_rvalid_o is high.
- init_done_o  out  1  high once the zero-fill is complete, or immediately if CLEAR_ON_RESET=0.
- sram_cen_o  out  1  chip enable, active-low.
- sram_gwen_o  out  1  global write enable, active-low.
- sram_ben_o  out  4  byte write enables, active-low.
- sram_a_o  out  13  address.
- sram_d_o  out  32  write data.
- sram_q_i  in  32  read data from the macro, valid one cycle after the read access.

## Operation
- FSM states: INIT, RUN.
  - Reset goes to INIT if CLEAR_ON_RESET=1, otherwise to RUN.
- INIT behaviour:
  - Macro pins per cycle: cen=0, gwen=0, ben=4'h0, a=clr_cnt, d=0.
  - clr_cnt is a 13-bit counter that starts at 0 and increments each cycle.
  - The write at clr_cnt=8191 is the last one; the FSM then goes to RUN.
  - Both grants are held at 0 for the whole INIT phase.
- RUN, arbitration:
  - A lone request is granted.
  - If both ports request, grant the port not named by `last`.
  - `last` is a 1-bit register updated to the granted port on every grant.
  - `last` resets to 1, so m0 wins the first conflict.
  - At most one grant per cycle.
- RUN, macro drive for the granted port:
  - cen=0, gwen=~we, ben=~be.
  - a and d come from the granted port.
  - A read drives ben=4'hF.
- RUN, idle cycle (no grant): cen=1, gwen=1, ben=4'hF, a=0, d=0.
- Response tracking:
  - Registers rv_q, rsel_q and rwe_q capture grant-valid, granted port and we.
  - The next cycle, mX_rvalid_o = rv_q & (rsel_q==X).
  - Read response: rdata = sram_q_i.
  - Write response, or port not selected: rdata = 0.
- Requests do not need to be held once granted. Back-to-back grants to the same port every cycle are legal when the other port is idle.

## Timing
- Grant latency is 0 cycles; response latency is 1 cycle for both reads and writes.
- Throughput is one access per cycle overall. Under continuous contention each port gets every other cycle.
- Reset values, applied at the first clk edge with rst_n=0:
  - FSM: INIT (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
  - clr_cnt=0, last=1, rv_q=0, rsel_q=0, rwe_q=0.
  - mX_rvalid_o=0, mX_rdata_o=0.
  - init_done_o = ~CLEAR_ON_RESET.
- While rst_n=0, grants are forced to 0 and the macro idles (cen=1, gwen=1, ben=4'hF) combinationally.
- Reset mid-INIT restarts the fill at address 0.
- Reset mid-RUN drops any pending response (rvalid never fires).
- init_done_o rises in the first RUN cycle, 8192 cycles after reset is released.
- A request raised in the same cycle INIT ends is not granted; it can first be granted in the first RUN cycle.

## Structure
- Package sram_arb_pkg holds:
  - ADDR_WIDTH=13, DATA_WIDTH=32, BE_WIDTH=4.
  - The state type {INIT, RUN}.
  - A constant for the idle macro value (cen=1, gwen=1, ben=4'hF).
- Sub-module rr_arb_2: two-way round-robin arbiter.
  - Inputs req[1:0], en; outputs gnt[1:0].
  - Holds the `last` register internally.
  - en is low during INIT and reset.
- Top level contains the FSM, clr_cnt, the macro mux, the response pipeline and the rdata demux.

## Test plan
- Zero-fill: CLEAR_ON_RESET=1, release reset → exactly 8192 cycles with cen=0, gwen=0, ben=0, a=0..8191, d=0. init_done_o rises in the next cycle. A read of address 0x1FFF returns 0.
- Lone read/write on m1 in RUN: write 0xDEADBEEF, be=4'b0101, addr 0x0123 → gwen=0, ben=4'b1010, m1_rvalid_o one cycle later. A later read of 0x0123 then returns 0x00AD00EF in rdata with m1_rvalid_o.
- Contention: m0 and m1 both request reads continuously for 6 cycles.
  - Grant order m0, m1, m0, m1, m0, m1.
  - Each rvalid goes only to the owning port, one cycle after its grant.
- Request during INIT: m0_req_i high from reset release → m0_gnt_o stays 0 until the first RUN cycle, then is 1.
- Reset mid-INIT: assert rst_n=0 at clr_cnt=100 → next INIT pass restarts at a=0, and init_done_o stays 0.
- Reset mid-RUN: assert rst_n=0 one cycle after a read grant → no rvalid, the macro idles, and last=1, so m0 wins the next conflict.
